// File: rtl/alu_arbiter.sv
// Purpose : two-port round-robin arbiter in front of one shared combinational ALU.
// Latency : req sampled at edge k -> operands to ALU after k, result captured at k+1, ack during cycle k+1..k+2.
// Backpressure: one operation in flight; requesters hold req and operands until their ack.
//
// Ports:
//   clk, reset (async, active-low)
//   req0/req1, a0/b0/a1/b1, shamt0/shamt1, op0/op1 : requester side inputs
//   ack0/ack1, res0/res1, eq0/eq1                   : per-requester completion
//   alu_a, alu_b, alu_shamt, alu_op / alu_c, alu_equal : shared ALU interface
//   busy, done_cnt                                  : status
// Build option: define ALU_ARB_FIXED_PRIO_EN to make port 0 win every contention
// (round robin otherwise).
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [4:0]  shamt0,
  input  logic [4:0]  shamt1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] res0,
  output logic [31:0] res1,
  output logic        eq0,
  output logic        eq1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_c,
  input  logic        alu_equal,
  output logic        busy,
  output logic [15:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [3:0]  op_q, op_d;
  logic        gnt_q, gnt_d;      // port id of the operation in flight
  logic [31:0] res_q, res_d;
  logic        eq_q, eq_d;
  logic [15:0] cnt_q, cnt_d;
  logic        win;               // port that would be granted this cycle

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Port 0 wins whenever it requests; port 1 only when alone.
  always_comb begin
    win = ~req0;
  end
`else
  logic last_q, last_d;

  // Under contention the port not served last goes next; otherwise the lone requester.
  always_comb begin
    if (req0 && req1) begin
      win = ~last_q;
    end else begin
      win = ~req0;
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == DONE) begin
      last_d = gnt_q;
    end
  end

  // Reset value 1 lets port 0 win the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    gnt_d   = gnt_q;
    res_d   = res_q;
    eq_d    = eq_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = win;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          shamt_d = win ? shamt1 : shamt0;
          op_d    = win ? op1 : op0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_c;
        eq_d    = alu_equal;
        state_d = DONE;
      end
      DONE: begin
        cnt_d   = cnt_q + 16'd1;  // natural 16-bit wrap
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      shamt_q <= 5'd0;
      op_q    <= 4'd0;
      gnt_q   <= 1'b0;
      res_q   <= 32'd0;
      eq_q    <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      gnt_q   <= gnt_d;
      res_q   <= res_d;
      eq_q    <= eq_d;
      cnt_q   <= cnt_d;
    end
  end

  // Acks decode straight from the state register so reset kills them at once.
  assign ack0      = (state_q == DONE) && !gnt_q;
  assign ack1      = (state_q == DONE) &&  gnt_q;
  assign busy      = (state_q != IDLE);
  assign res0      = res_q;
  assign res1      = res_q;
  assign eq0       = eq_q;
  assign eq1       = eq_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_shamt = shamt_q;
  assign alu_op    = op_q;
  assign done_cnt  = cnt_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-003 SHALL have: req0 / req1  in  1  requester 0/1 operation request, level.
REQ-004 SHALL have: a0, b0 / a1, b1  in  32 each  requester operands.
REQ-005 SHALL have: shamt0 / shamt1  in  5  and  op0 / op1  in  4  shift amount and 4-bit ALU opcode per requester.
REQ-006 SHALL have: ack0 / ack1  out  1  one-cycle completion strobe per requester.
REQ-007 SHALL have: res0 / res1  out  32  and  eq0 / eq1  out  1  result and Equal flag per requester.
REQ-008 SHALL have: alu_a, alu_b  out  32;  alu_shamt  out  5;  alu_op  out  4  drive to the shared ALU.
REQ-009 SHALL have: alu_c  in  32  and  alu_equal  in  1  result and Equal flag from the shared ALU.
REQ-010 SHALL have: busy  out  1  high when not IDLE;  done_cnt  out  16  count of completed operations.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, DONE; no other states are reachable.
REQ-012 IDLE: if no req is high at the clock edge, SHALL remain in IDLE.
REQ-013 IDLE with any req high at the edge: SHALL select a winner, latch its a/b/shamt/op into operand registers, record the grant id, and go to EXEC.
REQ-014 Arbitration, both req high: SHALL grant the port not granted last (round robin); last-grant resets to 1, so port 0 wins first.
REQ-015 Arbitration, single req high: SHALL grant that port regardless of last-grant.
REQ-016 alu_a/alu_b/alu_shamt/alu_op SHALL always equal the operand registers; values are unchanged outside the IDLE->EXEC edge.
REQ-017 EXEC: SHALL capture alu_c and alu_equal into a result register and go to DONE unconditionally; ALU is purely combinational, one cycle.
REQ-018 DONE: SHALL assert ack of the granted port only, for exactly one cycle.
REQ-019 DONE: SHALL update last-grant, increment done_cnt (16-bit, wraps 0xFFFF->0x0000), and go to IDLE.
REQ-020 res0/res1 and eq0/eq1 SHALL both show the result register at all times; they are meaningful only with the matching ack.
REQ-021 Latency: with req sampled at edge k, ack SHALL be high in the cycle after edge k+1; next grant no earlier than edge k+3.
REQ-022 Requester SHALL hold req and operands until ack; a req still high in IDLE after its ack SHALL start a new operation.
REQ-023 Requester operand or req changes during EXEC/DONE SHALL have no effect on the in-flight operation.
REQ-024 Opcodes SHALL pass through unmodified, including undefined ones; the arbiter performs no decoding.
REQ-025 ack0 and ack1 SHALL never be high together.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, ack0=ack1=0, busy=0, and clear operand regs, result reg, eq and done_cnt to 0, with last-grant=1.
REQ-027 Reset during EXEC or DONE SHALL discard the in-flight operation with no ack; after release, a held req SHALL be re-arbitrated from IDLE.

Configuration
REQ-028 With ALU_ARB_FIXED_PRIO_EN defined, both req high SHALL always grant port 0; last-grant is unused.
REQ-029 With ALU_ARB_FIXED_PRIO_EN undefined, arbitration SHALL be round robin per REQ-014.

Verification
REQ-030 Single op: req0, a0=5, b0=7, op0=0000 (ADD) -> ack0 two cycles after sampling edge, res0=12, eq0=0, done_cnt=1.
REQ-031 Simultaneous: after reset, req0 op ADD 1+1 and req1 op SUB 9-4 held -> ack0 res0=2 first, then ack1 res1=5; fixed-prio build: same order.
REQ-032 Fairness: both req continuously reasserted for 4 ops -> grants 0,1,0,1 (round robin); fixed-prio build -> 0,0,0,0.
REQ-033 Equal flag: req1, a1=b1=0x1234, op1=0001 -> ack1, res1=0, eq1=1; ack0 stays 0.
REQ-034 Reset mid-op: reset=0 during EXEC -> ack never fires, busy=0 at once, done_cnt=0; req0 held -> completes after release.
REQ-035 Wrap: preload via 65535 ops, one more op -> done_cnt=0x0000.
